hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/mdu_scoreboard.sv | 54 +++++
 rtl/hazard_ctrl.sv | 88 ++++++++
 tb/tb_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: multiply/divide scoreboard
// state encodings and the default execution latencies of the MDU.
package hazard_ctrl_pkg;

    // Scoreboard state as seen on the mduState output.
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MULT = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_state_t;

    // Default execution latencies in cycles (legal range 2..63 each).
    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;

    // Width of the busy-cycle down-counter; holds up to 63 cycles.
    localparam int MDU_CNT_W = 6;

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks whether the multiply/divide unit is busy and for how long.
// A start pulse loads the latency minus one; the unit stays busy until the
// counter has reached zero, giving exactly MULT_CYCLES / DIV_CYCLES busy cycles.
module mdu_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_div,
    output mdu_state_t state
);

    logic [MDU_CNT_W-1:0] count;

    // Scoreboard FSM and busy counter; reset wins over any start or count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_IDLE;
            count <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        // Divide wins if both flags are set by the decoder.
                        if (is_div) begin
                            state <= MDU_DIV;
                            count <= MDU_CNT_W'(DIV_CYCLES - 1);
                        end else begin
                            state <= MDU_MULT;
                            count <= MDU_CNT_W'(MULT_CYCLES - 1);
                        end
                    end
                end
                MDU_MULT, MDU_DIV: begin
                    // A taken branch never aborts the unit: counting continues.
                    if (count == '0) begin
                        state <= MDU_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= MDU_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use and multiply/divide hazards,
// resolves them against taken branches, issues MDU operations and counts
// stall cycles. Priority is branchTaken > load-use > MDU busy.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    input  logic        idIsMult,
    input  logic        idIsDiv,
    input  logic        idReadsHiLo,
    input  logic        exMemRead,
    input  logic [4:0]  exRt,
    input  logic        branchTaken,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        mduStart,
    output logic [1:0]  mduState,
    output logic [15:0] stallCount
);

    mdu_state_t sb_state;
    logic       load_use;
    logic       mdu_busy;
    logic       mdu_hazard;
    logic       stall;

    mdu_scoreboard #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_scoreboard (
        .clk   (clk),
        .rst   (rst),
        .start (mduStart),
        .is_div(idIsDiv),
        .state (sb_state)
    );

    assign mduState = sb_state;

    // Hazard detection; register 0 is never a real dependency.
    always_comb begin
        load_use   = exMemRead && (exRt != 5'd0) &&
                     ((idUsesRs && (idRs == exRt)) || (idUsesRt && (idRt == exRt)));
        mdu_busy   = (sb_state != MDU_IDLE);
        mdu_hazard = mdu_busy && (idReadsHiLo || idIsMult || idIsDiv);
    end

    // Priority resolution: flush on taken branch, else stall, else issue/advance.
    always_comb begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        mduStart  = 1'b0;
        stall     = 1'b0;
        if (branchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (load_use || mdu_hazard) begin
            stall     = 1'b1;
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
        end else if (!mdu_busy && (idIsMult || idIsDiv)) begin
            mduStart  = 1'b1;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
        end else if (stall && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with default latencies (mult 4, div 32).
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUsesRs;
    logic        idUsesRt;
    logic        idIsMult;
    logic        idIsDiv;
    logic        idReadsHiLo;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic        branchTaken;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        mduStart;
    logic [1:0]  mduState;
    logic [15:0] stallCount;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_stall = 16'd0;

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRs   (idUsesRs),
        .idUsesRt   (idUsesRt),
        .idIsMult   (idIsMult),
        .idIsDiv    (idIsDiv),
        .idReadsHiLo(idReadsHiLo),
        .exMemRead  (exMemRead),
        .exRt       (exRt),
        .branchTaken(branchTaken),
        .pcWrite    (pcWrite),
        .ifIdWrite  (ifIdWrite),
        .ifIdFlush  (ifIdFlush),
        .idExFlush  (idExFlush),
        .mduStart   (mduStart),
        .mduState   (mduState),
        .stallCount (stallCount)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        idRs = 5'd0; idRt = 5'd0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        idIsMult = 1'b0; idIsDiv = 1'b0; idReadsHiLo = 1'b0;
        exMemRead = 1'b0; exRt = 5'd0; branchTaken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        @(negedge clk);
        checks++; if (pcWrite !== 1'b1) begin errors++; $display("FAIL reset_pcWrite got=%b exp=1", pcWrite); end
        checks++; if (ifIdWrite !== 1'b1) begin errors++; $display("FAIL reset_ifIdWrite got=%b exp=1", ifIdWrite); end
        checks++; if (ifIdFlush !== 1'b0 || idExFlush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b%b exp=00", ifIdFlush, idExFlush); end
        checks++; if (mduStart !== 1'b0) begin errors++; $display("FAIL reset_mduStart got=%b exp=0", mduStart); end
        checks++; if (mduState !== 2'd0) begin errors++; $display("FAIL reset_mduState got=%0d exp=0", mduState); end
        checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL reset_stallCount got=%0d exp=0", stallCount); end
        step();
        rst = 1'b0;
        exp_stall = 16'd0;
    endtask

    task automatic test_load_use();
        // rs dependency on a load
        exMemRead = 1'b1; exRt = 5'd5; idUsesRs = 1'b1; idRs = 5'd5;
        @(negedge clk);
        checks++; if (pcWrite !== 1'b0 || ifIdWrite !== 1'b0) begin errors++; $display("FAIL lu_rs_hold got=%b%b exp=00", pcWrite, ifIdWrite); end
        checks++; if (idExFlush !== 1'b1 || ifIdFlush !== 1'b0) begin errors++; $display("FAIL lu_rs_flush got=%b%b exp=10", idExFlush, ifIdFlush); end
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL lu_rs_cnt_before got=%0d exp=%0d", stallCount, exp_stall); end
        step();
        exp_stall++;
        clear_inputs();
        @(negedge clk);
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL lu_rs_cnt_after got=%0d exp=%0d", stallCount, exp_stall); end
        checks++; if (pcWrite !== 1'b1 || idExFlush !== 1'b0) begin errors++; $display("FAIL lu_release got=%b%b exp=10", pcWrite, idExFlush); end
        // rt dependency
        step();
        exMemRead = 1'b1; exRt = 5'd7; idUsesRt = 1'b1; idRt = 5'd7; idRs = 5'd3; idUsesRs = 1'b1;
        @(negedge clk);
        checks++; if (pcWrite !== 1'b0 || idExFlush !== 1'b1) begin errors++; $display("FAIL lu_rt got=%b%b exp=01", pcWrite, idExFlush); end
        step();
        exp_stall++;
        // matching register but not read by the ID instruction
        idUsesRt = 1'b0;
        @(negedge clk);
        checks++; if (pcWrite !== 1'b1 || idExFlush !== 1'b0) begin errors++; $display("FAIL lu_unused got=%b%b exp=10", pcWrite, idExFlush); end
        // matching register but EX is not a load
        step();
        idUsesRt = 1'b1; exMemRead = 1'b0;
        @(negedge clk);
        checks++; if (pcWrite !== 1'b1) begin errors++; $display("FAIL lu_noload got=%b exp=1", pcWrite); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL lu_cnt_total got=%0d exp=%0d", stallCount, exp_stall); end
    endtask

    task automatic test_zero_reg();
        step();
        exMemRead = 1'b1; exRt = 5'd0; idUsesRs = 1'b1; idRs = 5'd0; idUsesRt = 1'b1; idRt = 5'd0;
        @(negedge clk);
        checks++; if (pcWrite !== 1'b1 || ifIdWrite !== 1'b1 || idExFlush !== 1'b0) begin errors++; $display("FAIL zero_reg got=%b%b%b exp=110", pcWrite, ifIdWrite, idExFlush); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL zero_reg_cnt got=%0d exp=%0d", stallCount, exp_stall); end
    endtask

    task automatic test_branch_priority();
        step();
        branchTaken = 1'b1; idIsMult = 1'b1;
        exMemRead = 1'b1; exRt = 5'd9; idUsesRs = 1'b1; idRs = 5'd9;
        @(negedge clk);
        checks++; if (ifIdFlush !== 1'b1 || idExFlush !== 1'b1) begin errors++; $display("FAIL br_flush got=%b%b exp=11", ifIdFlush, idExFlush); end
        checks++; if (pcWrite !== 1'b1 || ifIdWrite !== 1'b1) begin errors++; $display("FAIL br_write got=%b%b exp=11", pcWrite, ifIdWrite); end
        checks++; if (mduStart !== 1'b0) begin errors++; $display("FAIL br_mduStart got=%b exp=0", mduStart); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL br_cnt got=%0d exp=%0d", stallCount, exp_stall); end
        checks++; if (mduState !== 2'd0) begin errors++; $display("FAIL br_no_issue got=%0d exp=0", mduState); end
    endtask

    task automatic test_div();
        step();
        idIsDiv = 1'b1;
        @(negedge clk);
        checks++; if (mduStart !== 1'b1 || pcWrite !== 1'b1) begin errors++; $display("FAIL div_issue got=%b%b exp=11", mduStart, pcWrite); end
        step();
        idIsDiv = 1'b0; idReadsHiLo = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++; if (mduState !== 2'd2 || pcWrite !== 1'b0 || idExFlush !== 1'b1 || mduStart !== 1'b0) begin
                errors++; $display("FAIL div_busy cyc=%0d got state=%0d pc=%b fl=%b st=%b exp state=2 pc=0 fl=1 st=0", i, mduState, pcWrite, idExFlush, mduStart);
            end
            exp_stall++;
            step();
        end
        @(negedge clk);
        checks++; if (mduState !== 2'd0 || pcWrite !== 1'b1 || idExFlush !== 1'b0) begin errors++; $display("FAIL div_release got state=%0d pc=%b fl=%b exp 0 1 0", mduState, pcWrite, idExFlush); end
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL div_cnt got=%0d exp=%0d", stallCount, exp_stall); end
        step();
        clear_inputs();
    endtask

    task automatic test_div_wins();
        int busy;
        idIsMult = 1'b1; idIsDiv = 1'b1;
        @(negedge clk);
        checks++; if (mduStart !== 1'b1) begin errors++; $display("FAIL both_issue got=%b exp=1", mduStart); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (mduState !== 2'd2) begin errors++; $display("FAIL both_state got=%0d exp=2", mduState); end
        busy = 0;
        while (mduState != 2'd0 && busy < 40) begin
            busy++;
            step();
            @(negedge clk);
        end
        checks++; if (busy != 32) begin errors++; $display("FAIL both_busy_len got=%0d exp=32", busy); end
    endtask

    task automatic test_mult();
        step();
        idIsMult = 1'b1;
        @(negedge clk);
        checks++; if (mduStart !== 1'b1 || mduState !== 2'd0) begin errors++; $display("FAIL mult_issue got=%b/%0d exp=1/0", mduStart, mduState); end
        // second mult held in ID stalls for the whole busy period
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            checks++; if (mduState !== 2'd1 || mduStart !== 1'b0 || pcWrite !== 1'b0) begin
                errors++; $display("FAIL mult_busy cyc=%0d got state=%0d st=%b pc=%b exp 1 0 0", i, mduState, mduStart, pcWrite);
            end
            exp_stall++;
        end
        step();
        @(negedge clk);
        checks++; if (mduState !== 2'd0 || mduStart !== 1'b1) begin errors++; $display("FAIL mult_reissue got=%0d/%b exp=0/1", mduState, mduStart); end
        step();
        idIsMult = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (mduState !== 2'd1 || pcWrite !== 1'b1) begin errors++; $display("FAIL mult_free cyc=%0d got=%0d/%b exp=1/1", i, mduState, pcWrite); end
            step();
        end
        @(negedge clk);
        checks++; if (mduState !== 2'd0) begin errors++; $display("FAIL mult_done got=%0d exp=0", mduState); end
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL mult_cnt got=%0d exp=%0d", stallCount, exp_stall); end
    endtask

    task automatic test_branch_busy();
        step();
        idIsMult = 1'b1;
        @(negedge clk);
        checks++; if (mduStart !== 1'b1) begin errors++; $display("FAIL brb_issue got=%b exp=1", mduStart); end
        step();
        idIsMult = 1'b0; branchTaken = 1'b1;
        @(negedge clk);
        checks++; if (mduState !== 2'd1 || ifIdFlush !== 1'b1 || idExFlush !== 1'b1 || pcWrite !== 1'b1) begin
            errors++; $display("FAIL brb_flush got state=%0d fl=%b%b pc=%b exp 1 11 1", mduState, ifIdFlush, idExFlush, pcWrite);
        end
        step();
        branchTaken = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++; if (mduState !== 2'd1) begin errors++; $display("FAIL brb_continue got=%0d exp=1", mduState); end
        step();
        @(negedge clk);
        checks++; if (mduState !== 2'd0) begin errors++; $display("FAIL brb_done got=%0d exp=0", mduState); end
        checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL brb_cnt got=%0d exp=%0d", stallCount, exp_stall); end
    endtask

    task automatic test_reset_mid();
        step();
        idIsDiv = 1'b1;
        step();
        idIsDiv = 1'b0; idReadsHiLo = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mduState !== 2'd2) begin errors++; $display("FAIL rstmid_before got=%0d exp=2", mduState); end
        step();
        rst = 1'b0;
        exp_stall = 16'd0;
        @(negedge clk);
        checks++; if (mduState !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", mduState); end
        checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", stallCount); end
        checks++; if (pcWrite !== 1'b1 || idExFlush !== 1'b0) begin errors++; $display("FAIL rstmid_nostall got=%b%b exp=10", pcWrite, idExFlush); end
        step();
        clear_inputs();
    endtask

    task automatic test_saturate();
        exMemRead = 1'b1; exRt = 5'd12; idUsesRt = 1'b1; idRt = 5'd12;
        for (int i = 0; i < 70000; i++) step();
        @(negedge clk);
        checks++; if (stallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_value got=%0d exp=65535", stallCount); end
        step();
        @(negedge clk);
        checks++; if (stallCount !== 16'hFFFF || pcWrite !== 1'b0) begin errors++; $display("FAIL sat_hold got=%0d/%b exp=65535/0", stallCount, pcWrite); end
        step();
        clear_inputs();
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_priority();
        test_div();
        test_div_wins();
        test_mult();
        test_branch_busy();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
